adc_interleave_sched_8ch: RTL

Sequencer for the 8-channel interleaved ADC selection path. Given a channel-enable mask and a per-channel dwell time, it walks the enabled channels in ascending order and drives the 3-bit `x_adc_select` of the downstream 1-cycle-latency mux. It also produces a `sample_valid` / `sample_ch` tag that is cycle-aligned with the mux's registered output, so back-end consumers know which channel each `x_adc` word belongs to. It supports single-sweep and continuous modes, with graceful stop.

---
 rtl/adc_interleave_sched_8ch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adc_interleave_sched_8ch.sv
// Interleaved ADC channel sequencer: walks enabled channels in ascending order and tags
// each sample so the tag lines up with the downstream mux's registered output.
module adc_interleave_sched_8ch #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               GlobalReset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         ch_enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         x_adc_select,
    output logic               sample_valid,
    output logic [2:0]         sample_ch,
    output logic               sweep_done,
    output logic               busy,
    output logic               err_no_ch
);
    // state | meaning
    // IDLE  | waiting for start; select holds its last value
    // SCAN  | dwelling on sel_q, then advancing through act_mask_q
    // DRAIN | one cycle presenting the final sample_valid, then IDLE

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         act_mask_q, act_mask_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [2:0]         sel_q, sel_d;
    logic               sample_valid_q, sample_valid_d;
    logic [2:0]         sample_ch_q, sample_ch_d;
    logic               sweep_done_q, sweep_done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [7:0]         higher;
    logic               stop_eff;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        lowest_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_ch = 3'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q        <= IDLE;
            act_mask_q     <= '0;
            mode_q         <= 1'b0;
            dwell_q        <= '0;
            cnt_q          <= '0;
            stop_pend_q    <= 1'b0;
            sel_q          <= 3'd0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 3'd0;
            sweep_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            act_mask_q     <= act_mask_d;
            mode_q         <= mode_d;
            dwell_q        <= dwell_d;
            cnt_q          <= cnt_d;
            stop_pend_q    <= stop_pend_d;
            sel_q          <= sel_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sweep_done_q   <= sweep_done_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        act_mask_d     = act_mask_q;
        mode_d         = mode_q;
        dwell_d        = dwell_q;
        cnt_d          = cnt_q;
        stop_pend_d    = stop_pend_q;
        sel_d          = sel_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sweep_done_d   = 1'b0;
        busy_d         = busy_q;
        err_d          = 1'b0;
        // channels of the current sweep strictly above the one being dwelt on
        higher         = act_mask_q & ~((8'd2 << sel_q) - 8'd1);
        stop_eff       = stop_pend_q | stop;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ch_enable != 8'd0) begin
                        act_mask_d  = ch_enable;
                        mode_d      = mode;
                        dwell_d     = dwell;
                        sel_d       = lowest_ch(ch_enable);
                        cnt_d       = '0;
                        stop_pend_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                stop_pend_d = stop_eff;
                if (cnt_q == dwell_q) begin
                    sample_valid_d = 1'b1;
                    sample_ch_d    = sel_q;
                    cnt_d          = '0;
                    if (higher != 8'd0) begin
                        if (stop_eff) state_d = DRAIN;
                        else          sel_d   = lowest_ch(higher);
                    end else begin
                        sweep_done_d = 1'b1;
                        if (mode_q && !stop_eff) begin
                            // mask edits in continuous mode are only honoured here
                            if (ch_enable != 8'd0) begin
                                act_mask_d = ch_enable;
                                sel_d      = lowest_ch(ch_enable);
                            end else begin
                                err_d   = 1'b1;
                                state_d = DRAIN;
                            end
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            DRAIN: begin
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_adc_select = sel_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sweep_done   = sweep_done_q;
    assign busy         = busy_q;
    assign err_no_ch    = err_q;

endmodule
